tag_nios_system_sram_arbiter: RTL and testbench

TAG_NIOS_SYSTEM_SRAM_ARBITER -- requirements
Module: tag_nios_system_sram_arbiter

---
 rtl/tag_nios_system_sram_arbiter.sv | 138 +++++++++++++
 tb/tb_tag_nios_system_sram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_nios_system_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous SRAM.
// Latency: commands are granted in the request cycle; read data returns 2 cycles after acceptance.
// Backpressure: the losing requester sees mN_waitrequest high; waitrequest is high on both ports during reset.
//
// Ports:
//   clk, reset                      sole clock, asynchronous active-high reset
//   mN_address/read/write           requester N command (N=0,1); read+write together counts as a write
//   mN_writedata/byteenable         requester N write payload
//   mN_waitrequest                  requester N command not accepted this cycle
//   mN_readdata/readdatavalid       requester N read return, readdata holds between pulses
//   mem_*                           SRAM command (combinational from the granted port), mem_readdata next cycle
//
// Build option: define SRAM_ARB_FIXED_PRIORITY_EN to make port 0 always win
// contention (no last-grant register); otherwise arbitration is round-robin.
module tag_nios_system_sram_arbiter #(
  parameter int          NUM_WORDS = 13312,
  parameter logic [31:0] OOR_DATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [13:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [13:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  input  logic [31:0] mem_readdata
);

  // One extra bit so NUM_WORDS up to 16384 compares cleanly against a 14-bit address.
  localparam logic [14:0] WORDS_LIMIT = 15'(NUM_WORDS);

  logic        req0, req1;
  logic        grant0, grant1, granted;
  logic [13:0] sel_address;
  logic        sel_write;
  logic        sel_oor;
  logic        rd_accept;

  // Read pipeline stage 1: tag travelling alongside the SRAM access.
  logic        s1_vld;
  logic        s1_port;
  logic        s1_oor;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  assign grant0 = req0 & ~reset;
`else
  // last_grant == 1 means port 1 was served most recently, so port 0 wins a tie.
  logic last_grant;

  assign grant0 = req0 & (~req1 | last_grant) & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant0 | grant1) begin
      last_grant <= grant1;
    end
  end
`endif

  assign grant1  = req1 & ~grant0 & ~reset;
  assign granted = grant0 | grant1;

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  always_comb begin
    sel_address    = m0_address;
    sel_write      = m0_write;
    mem_writedata  = m0_writedata;
    mem_byteenable = m0_byteenable;
    if (grant1) begin
      sel_address    = m1_address;
      sel_write      = m1_write;
      mem_writedata  = m1_writedata;
      mem_byteenable = m1_byteenable;
    end
  end

  assign sel_oor     = ({1'b0, sel_address} >= WORDS_LIMIT);
  assign mem_address = sel_address;
  // Out-of-range commands never reach the SRAM; reads are answered from OOR_DATA instead.
  assign mem_chipselect = granted & ~sel_oor;
  assign mem_write      = granted & sel_write & ~sel_oor;
  // Read+write together is a write, so only a pure read enters the return pipeline.
  assign rd_accept      = granted & ~sel_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_port <= 1'b0;
      s1_oor  <= 1'b0;
    end else begin
      s1_vld  <= rd_accept;
      s1_port <= grant1;
      s1_oor  <= sel_oor;
    end
  end

  // Stage 2: mem_readdata is valid while stage 1 holds the tag; capture into the issuing port only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      m0_readdatavalid <= s1_vld & ~s1_port;
      m1_readdatavalid <= s1_vld & s1_port;
      if (s1_vld & ~s1_port) begin
        m0_readdata <= s1_oor ? OOR_DATA : mem_readdata;
      end
      if (s1_vld & s1_port) begin
        m1_readdata <= s1_oor ? OOR_DATA : mem_readdata;
      end
    end
  end

endmodule

// File: tb/tb_tag_nios_system_sram_arbiter.sv
// Bench for the two-port SRAM arbiter: directed scenarios plus random traffic.
// Expected grants and read data come from a behavioural model (tie-break bit + word array).
// Read returns are queued per port with their due cycle and checked by an independent monitor.
module tb_tag_nios_system_sram_arbiter;
  localparam int          NUM_WORDS = 13312;
  localparam logic [31:0] OOR_DATA  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_readdata;

  tag_nios_system_sram_arbiter #(.NUM_WORDS(NUM_WORDS), .OOR_DATA(OOR_DATA)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Environment: synchronous single-port SRAM, byte-lane writes, read data the next cycle.
  logic [31:0] sram [16384];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) sram[mem_address][b*8 +: 8] = mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= sram[mem_address];
      end
    end
  end

  // Reference model state.
  typedef struct { int cyc; logic [31:0] d; } rd_t;
  rd_t         q0[$], q1[$];
  logic [31:0] ref_mem [NUM_WORDS];
  logic        prefer0;            // 1: port 0 wins the next tie
  logic [31:0] last_rd [2];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Monitor: compares every read return against the head of the issuing port's queue.
  task automatic mon_port(input int p, input logic vld, input logic [31:0] dat);
    rd_t e;
    if (vld !== 1'b1) begin
      chk(p == 0 ? "rd_hold0" : "rd_hold1", dat, last_rd[p]);
      return;
    end
    if ((p == 0 ? q0.size() : q1.size()) == 0) begin
      chk(p == 0 ? "unexpected_valid0" : "unexpected_valid1", 32'(vld), 32'd0);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    chk(p == 0 ? "rd_data0" : "rd_data1", dat, e.d);
    chk(p == 0 ? "rd_latency0" : "rd_latency1", 32'(cyc), 32'(e.cyc + 2));
    last_rd[p] = e.d;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("rst_valid0", 32'(m0_readdatavalid), 32'd0);
      chk("rst_valid1", 32'(m1_readdatavalid), 32'd0);
      chk("rst_data0", m0_readdata, 32'd0);
      chk("rst_data1", m1_readdata, 32'd0);
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else if (reset === 1'b0) begin
      mon_port(0, m0_readdatavalid, m0_readdata);
      mon_port(1, m1_readdatavalid, m1_readdata);
    end
  end

  // One bus cycle: called at posedge+1, drives both requesters, checks the
  // combinational grant at negedge, updates the model, returns at next posedge+1.
  task automatic bus_cycle(
    input logic r0, input logic w0, input logic [13:0] a0, input logic [31:0] d0, input logic [3:0] be0,
    input logic r1, input logic w1, input logic [13:0] a1, input logic [31:0] d1, input logic [3:0] be1);
    logic g0, g1, gw, goor;
    logic [13:0] ga;
    logic [31:0] gd;
    logic [3:0]  gbe;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = be0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = be1;
    @(negedge clk);
    if (reset) begin
      chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
      chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
      chk("rst_cs", 32'(mem_chipselect), 32'd0);
      q0.delete();
      q1.delete();
      prefer0 = 1'b1;
    end else begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      g0 = r0 | w0;
`else
      g0 = (r0 | w0) & (!(r1 | w1) || prefer0);
`endif
      g1 = (r1 | w1) & !g0;
      chk("wait0", 32'(m0_waitrequest), 32'((r0 | w0) & !g0));
      chk("wait1", 32'(m1_waitrequest), 32'((r1 | w1) & !g1));
      ga = g1 ? a1 : a0; gw = g1 ? w1 : w0; gd = g1 ? d1 : d0; gbe = g1 ? be1 : be0;
      goor = (int'(ga) >= NUM_WORDS);
      chk("chipselect", 32'(mem_chipselect), 32'((g0 | g1) & !goor));
      if ((g0 | g1) && !goor) begin
        chk("mem_address", 32'(mem_address), 32'(ga));
        chk("mem_write", 32'(mem_write), 32'(gw));
        if (gw) begin
          chk("mem_writedata", mem_writedata, gd);
          chk("mem_byteenable", 32'(mem_byteenable), 32'(gbe));
        end
      end
      if (g0 | g1) begin
        prefer0 = g1;
        if (gw) begin
          if (!goor) ref_mem[ga] = merge(ref_mem[ga], gd, gbe);
        end else begin
          rd_t e;
          e.cyc = cyc;
          e.d   = goor ? OOR_DATA : ref_mem[ga];
          if (g1) q1.push_back(e); else q0.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [13:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 14'(13309 + $urandom_range(0, 6));
    return 14'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = i * 32'h9E3779B1;
    sram[16'h0010] = 32'h12345678;
    sram[16'h0100] = 32'h0;
    for (int i = 0; i < NUM_WORDS; i++) ref_mem[i] = sram[i];
    last_rd[0] = '0;
    last_rd[1] = '0;
    prefer0 = 1'b1;
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Single read from port 0.
    bus_cycle(1, 0, 14'h0010, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Contention from reset state: six cycles of both ports reading.
    reset = 1'b1; idle(1); reset = 1'b0;
    for (int i = 0; i < 6; i++)
      bus_cycle(1, 0, 14'(32 + i), 0, 0, 1, 0, 14'(48 + i), 0, 0);
    idle(3);

    // Byte-lane write then read back.
    bus_cycle(0, 0, 0, 0, 0, 0, 1, 14'h0100, 32'hAABBCCDD, 4'b0101);
    bus_cycle(0, 0, 0, 0, 0, 1, 0, 14'h0100, 0, 0);
    idle(3);

    // Range boundary, plus read+write together acting as a write.
    bus_cycle(0, 1, 14'd13312, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 0);
    bus_cycle(1, 0, 14'd13312, 0, 0, 0, 0, 0, 0, 0);
    bus_cycle(0, 1, 14'd13311, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0);
    bus_cycle(1, 0, 14'd13311, 0, 0, 0, 0, 0, 0, 0);
    bus_cycle(1, 1, 14'd5, 32'hCAFE0005, 4'hF, 0, 0, 0, 0, 0);
    bus_cycle(1, 0, 14'd5, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Write from port 0 immediately followed by a read of the same word from port 1.
    bus_cycle(0, 1, 14'h0200, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 0, 0);
    bus_cycle(0, 0, 0, 0, 0, 1, 0, 14'h0200, 0, 0);
    idle(3);

    // Reset while a read is in flight, then a tie must go to port 0.
    bus_cycle(0, 0, 0, 0, 0, 1, 0, 14'd3, 0, 0);
    bus_cycle(1, 0, 14'd7, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    bus_cycle(1, 0, 14'd9, 0, 0, 1, 0, 14'd10, 0, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic r0, w0, r1, w1;
      r0 = ($urandom_range(0, 2) != 0); w0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 2) != 0); w1 = ($urandom_range(0, 3) == 0);
      bus_cycle(r0, w0, rand_addr(), $urandom, 4'($urandom),
                r1, w1, rand_addr(), $urandom, 4'($urandom));
    end
    idle(4);

    chk("pending0_empty", 32'(q0.size()), 32'd0);
    chk("pending1_empty", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
